ultrasound_sweep_collector: RTL and testbench

- Produces the five 8-bit distance inputs consumed by the 5-way minimum finder.
- Steps the ultrasound servo through positions 1..5 (15/30/45/60/75 deg). At each position it waits for mechanical settle, requests one ranging measurement and captures the returned distance.
- Presents all five distances together with a one-cycle valid strobe.
- Sits between the sweep controller (start) and the ultrasound ranging front end on one side, and the min-finder on the other.

---
 rtl/ultrasound_sweep_collector_pkg.sv | 34 +++
 rtl/ultrasound_sweep_collector_if.sv | 32 +++
 rtl/ultrasound_sweep_collector_cycle_timer.sv | 28 ++
 rtl/ultrasound_sweep_collector.sv | 146 ++++++++++++++
 tb/tb_ultrasound_sweep_collector.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ultrasound_sweep_collector_pkg.sv
// Shared constants and types for the ultrasound sweep collector and its neighbours
// (min-finder consumes NUM_POS distances, servo PWM block uses the angle table).
package ultrasound_sweep_collector_pkg;

    localparam int NUM_POS = 5;
    localparam int DIST_W  = 8;

    typedef logic [DIST_W-1:0]               dist_t;
    typedef logic [NUM_POS-1:0][DIST_W-1:0]  dist_vec_t;

    localparam dist_t TIMEOUT_VALUE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Servo angle in degrees for a 1-based position; 0 (park) and anything else map to 0.
    function automatic logic [7:0] servo_angle(input logic [2:0] idx);
        case (idx)
            3'd1:    return 8'd15;
            3'd2:    return 8'd30;
            3'd3:    return 8'd45;
            3'd4:    return 8'd60;
            3'd5:    return 8'd75;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/ultrasound_sweep_collector_if.sv
// Sweep collector bus: start/busy from the controller, ranging handshake, and the
// five distances plus valid strobe toward the min-finder.
interface ultrasound_sweep_collector_if;
    import ultrasound_sweep_collector_pkg::*;

    logic               start;
    logic [2:0]         servo_index;
    logic               meas_req;
    logic               meas_valid;
    dist_t              meas_dist;
    dist_t              dist1;
    dist_t              dist2;
    dist_t              dist3;
    dist_t              dist4;
    dist_t              dist5;
    logic               sweep_valid;
    logic               busy;
    logic [NUM_POS-1:0] timeout_flags;

    modport master (
        input  start, meas_valid, meas_dist,
        output servo_index, meas_req, dist1, dist2, dist3, dist4, dist5,
               sweep_valid, busy, timeout_flags
    );

    modport slave (
        output start, meas_valid, meas_dist,
        input  servo_index, meas_req, dist1, dist2, dist3, dist4, dist5,
               sweep_valid, busy, timeout_flags
    );

endinterface

// File: rtl/ultrasound_sweep_collector_cycle_timer.sv
// Loadable down-counter shared by the settle and measurement-timeout waits;
// terminal is high while the count reads 1, i.e. on the last cycle of a wait.
module ultrasound_sweep_collector_cycle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    // Holding at zero keeps an idle timer from wrapping into a false terminal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign terminal = (count == CNT_W'(1));

endmodule

// File: rtl/ultrasound_sweep_collector.sv
// Steps the ranging servo through five positions, takes one measurement per position
// and publishes all five distances together with a one-cycle sweep_valid strobe.
module ultrasound_sweep_collector
    import ultrasound_sweep_collector_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1350000,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input logic                          clock,
    input logic                          reset_n,
    ultrasound_sweep_collector_if.master bus
);

    localparam int MAX_CYC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);

    state_t             state, state_nxt;
    logic [2:0]         pos;
    logic               last_pos;
    logic [2:0]         servo_q;
    logic               sweep_valid_q;
    dist_vec_t          shadow, dist_q;
    logic [NUM_POS-1:0] tflag, tflag_q;

    logic               meas_req, busy;
    logic               tmr_load, tmr_dec, tmr_term;
    logic [CNT_W-1:0]   tmr_value;

    assign last_pos = (pos == 3'(NUM_POS));

    ultrasound_sweep_collector_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .terminal   (tmr_term)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A reply in the same cycle as the timeout still counts as a real measurement.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_MOVE;
            ST_MOVE:  if (tmr_term) state_nxt = ST_REQ;
            ST_REQ:   state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.meas_valid || tmr_term) state_nxt = ST_STORE;
            ST_STORE: state_nxt = last_pos ? ST_DONE : ST_MOVE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        meas_req  = 1'b0;
        busy      = 1'b1;
        tmr_load  = 1'b0;
        tmr_value = SETTLE_LD;
        tmr_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                tmr_load = bus.start;
            end
            ST_MOVE: tmr_dec = 1'b1;
            ST_REQ: begin
                meas_req  = 1'b1;
                tmr_load  = 1'b1;
                tmr_value = TIMEOUT_LD;
            end
            ST_WAIT:  tmr_dec = 1'b1;
            ST_STORE: tmr_load = !last_pos;
            default: ;
        endcase
    end

    // Results land in shadow registers so a partial sweep never touches dist_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos           <= '0;
            servo_q       <= '0;
            sweep_valid_q <= 1'b0;
            shadow        <= '0;
            tflag         <= '0;
            dist_q        <= '0;
            tflag_q       <= '0;
        end else begin
            sweep_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        pos     <= 3'd1;
                        servo_q <= 3'd1;
                    end
                end
                ST_WAIT: begin
                    for (int i = 0; i < NUM_POS; i++) begin
                        if (pos == 3'(i + 1)) begin
                            if (bus.meas_valid) begin
                                shadow[i] <= bus.meas_dist;
                                tflag[i]  <= 1'b0;
                            end else if (tmr_term) begin
                                shadow[i] <= TIMEOUT_VALUE;
                                tflag[i]  <= 1'b1;
                            end
                        end
                    end
                end
                ST_STORE: begin
                    if (!last_pos) begin
                        pos     <= pos + 3'd1;
                        servo_q <= pos + 3'd1;
                    end
                end
                ST_DONE: begin
                    dist_q        <= shadow;
                    tflag_q       <= tflag;
                    sweep_valid_q <= 1'b1;
                    servo_q       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.servo_index   = servo_q;
    assign bus.meas_req      = meas_req;
    assign bus.busy          = busy;
    assign bus.sweep_valid   = sweep_valid_q;
    assign bus.timeout_flags = tflag_q;
    assign bus.dist1         = dist_q[0];
    assign bus.dist2         = dist_q[1];
    assign bus.dist3         = dist_q[2];
    assign bus.dist4         = dist_q[3];
    assign bus.dist5         = dist_q[4];

endmodule

// File: tb/tb_ultrasound_sweep_collector.sv
// Directed bench: a cycle timeline model built from per-position segment lengths
// predicts every output each cycle; a few literal checks pin the model.
module tb_ultrasound_sweep_collector;

    localparam int S = 4;
    localparam int T = 16;
    localparam int N = 400;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_req = 0;
    int   n_sv = 0;
    int   sv1;
    int   sv_tmp;

    // Stimulus per cycle
    bit         drv_rstn [N];
    bit         drv_start[N];
    bit         drv_valid[N];
    logic [7:0] drv_dist [N];
    // Expected outputs per cycle
    logic [2:0]  exp_servo[N];
    bit          exp_req  [N];
    bit          exp_busy [N];
    bit          exp_sv   [N];
    logic [39:0] exp_dist [N];
    logic [4:0]  exp_tf   [N];

    ultrasound_sweep_collector_if bus();

    ultrasound_sweep_collector #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    // Sweep starting with start high in cycle c0. dly[p] = cycles from meas_req to the
    // reply (0 = no reply). Each position spans S move + 1 req + W wait + 1 store cycles.
    task automatic plan_sweep(input int c0, input int dly[5], input logic [7:0] val[5],
                              output int sv_cyc);
        int b, w;
        logic [39:0] nd;
        logic [4:0]  nf;
        b = c0 + 1;
        drv_start[c0] = 1'b1;
        for (int p = 0; p < 5; p++) begin
            w = (dly[p] >= 1 && dly[p] <= T) ? dly[p] : T;
            for (int k = b; k < b + S + 1 + w + 1; k++) begin
                exp_servo[k] = 3'(p + 1);
                exp_busy[k]  = 1'b1;
            end
            exp_req[b + S] = 1'b1;
            if (dly[p] != 0) begin
                drv_valid[b + S + dly[p]] = 1'b1;
                drv_dist[b + S + dly[p]]  = val[p];
                nd[p*8 +: 8] = val[p];
                nf[p]        = 1'b0;
            end else begin
                nd[p*8 +: 8] = 8'hFF;
                nf[p]        = 1'b1;
            end
            b = b + S + 1 + w + 1;
        end
        exp_servo[b] = 3'd5;
        exp_busy[b]  = 1'b1;
        sv_cyc = b + 1;
        exp_sv[sv_cyc] = 1'b1;
        for (int k = sv_cyc; k < N; k++) begin
            exp_dist[k] = nd;
            exp_tf[k]   = nf;
        end
    endtask

    task automatic reset_at(input int r, input int len);
        for (int k = r; k < N; k++) begin
            exp_servo[k] = '0;
            exp_req[k]   = 1'b0;
            exp_busy[k]  = 1'b0;
            exp_sv[k]    = 1'b0;
            exp_dist[k]  = '0;
            exp_tf[k]    = '0;
            drv_valid[k] = 1'b0;
            drv_dist[k]  = '0;
        end
        for (int k = r; k < r + len; k++) drv_rstn[k] = 1'b0;
    endtask

    always @(negedge clock) begin
        if (cyc >= 1 && cyc < N) begin
            chk("servo_index", 64'(bus.servo_index), 64'(exp_servo[cyc]));
            chk("meas_req", 64'(bus.meas_req), 64'(exp_req[cyc]));
            chk("busy", 64'(bus.busy), 64'(exp_busy[cyc]));
            chk("sweep_valid", 64'(bus.sweep_valid), 64'(exp_sv[cyc]));
            chk("dists", 64'({bus.dist5, bus.dist4, bus.dist3, bus.dist2, bus.dist1}),
                64'(exp_dist[cyc]));
            chk("timeout_flags", 64'(bus.timeout_flags), 64'(exp_tf[cyc]));
            if (bus.meas_req) n_req++;
            if (bus.sweep_valid) n_sv++;
            // Hand-computed anchors
            if (cyc == 2) begin
                chk("rst_servo", 64'(bus.servo_index), 64'd0);
                chk("rst_busy", 64'(bus.busy), 64'd0);
                chk("rst_dist1", 64'(bus.dist1), 64'd0);
                chk("rst_flags", 64'(bus.timeout_flags), 64'd0);
            end
            if (cyc == 52) begin
                chk("norm_sv", 64'(bus.sweep_valid), 64'd1);
                chk("norm_dist1", 64'(bus.dist1), 64'd40);
                chk("norm_dist3", 64'(bus.dist3), 64'd20);
                chk("norm_flags", 64'(bus.timeout_flags), 64'd0);
            end
            if (cyc == 119) chk("hold_dist3", 64'(bus.dist3), 64'd20);
            if (cyc == 120) begin
                chk("to_dist3", 64'(bus.dist3), 64'hFF);
                chk("to_flags", 64'(bus.timeout_flags), 64'b00100);
                chk("to_dist4", 64'(bus.dist4), 64'd30);
            end
            if (cyc == 190) begin
                chk("sim_dist2", 64'(bus.dist2), 64'h22);
                chk("sim_flag1", 64'(bus.timeout_flags[1]), 64'd0);
            end
            if (cyc == 247) chk("pre_dist5", 64'(bus.dist5), 64'd50);
            if (cyc == 280) begin
                chk("mid_rst_servo", 64'(bus.servo_index), 64'd0);
                chk("mid_rst_busy", 64'(bus.busy), 64'd0);
                chk("mid_rst_dist5", 64'(bus.dist5), 64'd0);
            end
            if (cyc == 337) chk("b2b_idle", 64'(bus.busy), 64'd0);
            if (cyc == 338) chk("b2b_busy", 64'(bus.busy), 64'd1);
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            drv_rstn[k] = 1'b1; drv_start[k] = 1'b0; drv_valid[k] = 1'b0; drv_dist[k] = '0;
            exp_servo[k] = '0; exp_req[k] = 1'b0; exp_busy[k] = 1'b0; exp_sv[k] = 1'b0;
            exp_dist[k] = '0; exp_tf[k] = '0;
        end
        reset_at(0, 3);
        // Normal sweep
        plan_sweep(5, '{3, 3, 3, 3, 3}, '{8'd40, 8'd30, 8'd20, 8'd30, 8'd40}, sv1);
        // Timeout at position 3, stray start in MOVE, late reply in the next MOVE
        plan_sweep(60, '{3, 3, 0, 3, 3}, '{8'd40, 8'd30, 8'd0, 8'd30, 8'd40}, sv_tmp);
        drv_start[62] = 1'b1;
        drv_valid[102] = 1'b1;
        drv_dist[102]  = 8'h10;
        // Reply coincides with the last WAIT cycle at position 2
        plan_sweep(130, '{3, 16, 3, 3, 3}, '{8'd1, 8'h22, 8'd3, 8'd4, 8'd5}, sv_tmp);
        // Full sweep, then a sweep cut by reset during position 3 WAIT
        plan_sweep(200, '{3, 3, 3, 3, 3}, '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50}, sv_tmp);
        plan_sweep(255, '{3, 3, 3, 3, 3}, '{8'd60, 8'd61, 8'd62, 8'd63, 8'd64}, sv_tmp);
        reset_at(280, 2);
        // start held high: back-to-back sweeps
        plan_sweep(290, '{3, 3, 3, 3, 3}, '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, sv_tmp);
        plan_sweep(sv_tmp, '{3, 3, 3, 3, 3}, '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5}, sv_tmp);
        for (int k = 290; k <= 337; k++) drv_start[k] = 1'b1;

        bus.start      = 1'b0;
        bus.meas_valid = 1'b0;
        bus.meas_dist  = '0;
        reset_n        = 1'b1;
        #1 reset_n     = 1'b0;
        while (cyc < N - 1) begin
            @(posedge clock);
            cyc = cyc + 1;
            #1;
            reset_n        = drv_rstn[cyc];
            bus.start      = drv_start[cyc];
            bus.meas_valid = drv_valid[cyc];
            bus.meas_dist  = drv_dist[cyc];
        end
        chk("model_latency", 64'(sv1 - 5), 64'd47);
        chk("req_count", 64'(n_req), 64'd33);
        chk("sweep_count", 64'(n_sv), 64'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
